// File: rtl/ysyx_22050368_redirect_ctrl.sv
// ============================================================================
// Module      : ysyx_22050368_redirect_ctrl
// Description : Sequences a taken-jump redirect from EX to the IFU: flushes
//               IF/ID and ID/EX, hands the target to the IFU over a
//               valid/ready handshake, and drops wrong-path fetch responses
//               still in flight. Also traps misaligned targets and counts
//               accepted redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050368_redirect_ctrl #(
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_jump_flag,
  input  logic [XLEN-1:0] ex_jump_addr,
  input  logic            ifu_req_fire,
  input  logic            ifu_resp_valid,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_addr,
  input  logic            redir_ready,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            discard_resp,
  output logic            ex_stall,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic [31:0]     redir_cnt
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] raddr_q, raddr_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            flush_q, flush_d;
  logic            mexc_q, mexc_d;
  logic            jump_qual;
  logic            target_aligned;

  assign jump_qual      = ex_valid & ex_jump_flag;
  assign target_aligned = (ex_jump_addr[1:0] == 2'b00);

  // In-flight fetch count after this cycle; a lone response at zero is ignored
  always_comb begin
    if (ifu_resp_valid && !ifu_req_fire && (outstanding_q == '0)) begin
      outstanding_d = outstanding_q;
    end else begin
      outstanding_d = outstanding_q + CW'(ifu_req_fire) - CW'(ifu_resp_valid);
    end
  end

  // Next-state and output decode for the redirect sequencer
  always_comb begin
    state_d      = state_q;
    stale_d      = stale_q;
    cnt_d        = cnt_q;
    raddr_d      = raddr_q;
    maddr_d      = maddr_q;
    flush_d      = 1'b0;
    mexc_d       = 1'b0;
    redir_valid  = 1'b0;
    discard_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (jump_qual) begin
          if (target_aligned) begin
            raddr_d = ex_jump_addr;
            flush_d = 1'b1;
            state_d = ST_REDIR;
          end else begin
            maddr_d = ex_jump_addr;
            mexc_d  = 1'b1;
          end
        end
      end

      ST_REDIR: begin
        redir_valid = 1'b1;
        if (redir_ready) begin
          cnt_d = cnt_q + 32'd1;
          // Anything still in flight once this cycle settles is wrong-path,
          // including a fetch fired in the acceptance cycle itself.
          stale_d = outstanding_d;
          state_d = (outstanding_d != '0) ? ST_DRAIN : ST_IDLE;
        end
      end

      ST_DRAIN: begin
        discard_resp = ifu_resp_valid;
        if (ifu_resp_valid) begin
          stale_d = stale_q - CW'(1);
          if (stale_q <= CW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any redirect or drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      stale_q       <= '0;
      cnt_q         <= '0;
      raddr_q       <= '0;
      maddr_q       <= '0;
      flush_q       <= 1'b0;
      mexc_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      cnt_q         <= cnt_d;
      raddr_q       <= raddr_d;
      maddr_q       <= maddr_d;
      flush_q       <= flush_d;
      mexc_q        <= mexc_d;
    end
  end

  assign ex_stall      = (state_q != ST_IDLE);
  assign redir_addr    = raddr_q;
  assign misalign_addr = maddr_q;
  assign flush_ifid    = flush_q;
  assign flush_idex    = flush_q;
  assign misalign_exc  = mexc_q;
  assign redir_cnt     = cnt_q;

endmodule

`default_nettype wire

// File: doc/ysyx_22050368_redirect_ctrl.md
# ysyx_22050368_redirect_ctrl

Control-flow redirect sequencer between the EXU branch/jump unit and the IFU. On a taken jump resolved in EX, it:
- latches the target and flushes the IF/ID and ID/EX registers;
- presents the target to the IFU over a valid/ready handshake;
- discards fetch responses still in flight from the wrong path.

It also traps misaligned jump targets and counts taken redirects.

## Interface
Parameters:
- XLEN, 64, address/data width
- MAX_OUTSTANDING, 4, maximum IFU fetches in flight; counter width is clog2(MAX_OUTSTANDING)+1

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ex_valid  input  1  EXU holds a valid instruction this cycle
- ex_jump_flag  input  1  branch/jump unit reports taken jump
- ex_jump_addr  input  XLEN  jump target from branch/jump unit
- ifu_req_fire  input  1  IFU fetch request accepted by memory this cycle
- ifu_resp_valid  input  1  IFU fetch response arriving this cycle; responses return in order
- redir_valid  output  1  redirect request to IFU
- redir_addr  output  XLEN  redirect target, stable while redir_valid
- redir_ready  input  1  IFU accepts redirect
- flush_ifid  output  1  one-cycle flush of IF/ID register
- flush_idex  output  1  one-cycle flush of ID/EX register
- discard_resp  output  1  IFU must drop the current response
- ex_stall  output  1  hold EXU; high whenever state is not IDLE
- misalign_exc  output  1  one-cycle misaligned-target exception pulse
- misalign_addr  output  XLEN  offending target, held until next exception
- redir_cnt  output  32  count of accepted redirects, wraps at 2^32

## Operation
- Reset:
  - state IDLE; outstanding=0, stale=0, redir_cnt=0.
  - Registered outputs cleared to 0: redir_addr, misalign_addr, flush_*, misalign_exc.
  - Combinational outputs are 0 while in IDLE: redir_valid, discard_resp, ex_stall.
  - Async rst mid-operation aborts any pending redirect or drain immediately.
- Outstanding counter: updated every cycle as +ifu_req_fire −ifu_resp_valid. A simultaneous fire and response leaves it unchanged. Never exceeds MAX_OUTSTANDING (IFU guarantees); holds at 0 on a response with outstanding=0.
- Qualifying jump = ex_valid & ex_jump_flag in IDLE.
  - Target aligned (ex_jump_addr[1:0]==0):
    - Latch redir_addr.
    - Go to REDIR.
    - Set flush_ifid=flush_idex=1 for the next cycle only.
  - Target misaligned:
    - Latch misalign_addr.
    - Pulse misalign_exc next cycle.
    - No redirect and no flush; stay IDLE.
- Jumps presented outside IDLE are ignored; ex_stall prevents them.
- FSM:
  - IDLE: waits for a qualifying jump.
  - REDIR:
    - redir_valid=1 and redir_addr held until redir_ready.
    - On acceptance, redir_cnt increments and stale is loaded with outstanding + ifu_req_fire − ifu_resp_valid, the in-flight count after this cycle. A fetch fired in the acceptance cycle counts as wrong-path.
    - Next state is DRAIN if stale>0, else IDLE.
  - DRAIN:
    - discard_resp = ifu_resp_valid.
    - stale decrements per response.
    - The response that brings stale to 0 is discarded; the FSM returns to IDLE on that edge.
    - New-path fetches issued during DRAIN are counted in outstanding but are not stale.
- ex_stall = (state != IDLE).

## Timing
- Jump in EX at cycle T produces flush_ifid, flush_idex and redir_valid at T+1.
- If redir_ready=1 at T+1, the next state takes effect at T+2. Minimum redirect latency is 1 cycle; back-to-back jumps are possible at T+2 when no drain is needed.
- redir_valid stays high for as many cycles as redir_ready stays low. The flush pulse is still a single cycle (T+1).
- Misaligned target at T produces misalign_exc at T+1 for exactly one cycle.
- discard_resp is combinational from ifu_resp_valid in DRAIN, in the same cycle as the response.
- DRAIN length equals the number of stale responses; there is no timeout.

## Test plan
- Aligned jump, immediate accept: ex_jump_addr=0x8000_0100, outstanding 0, redir_ready=1 at T+1.
  - Expect flush pulse and redir_valid at T+1 with redir_addr=0x8000_0100, and IDLE at T+2.
  - Expect redir_cnt=1.
- Backpressure: redir_ready low for 3 cycles.
  - Expect redir_valid high for 4 cycles with stable addr and a flush only in the first cycle.
  - Expect ex_stall high throughout.
- Drain: 2 fetches outstanding, plus 1 ifu_req_fire in the acceptance cycle.
  - Expect stale=3.
  - Expect the next 3 responses flagged discard_resp, with the 4th response not flagged.
- Misaligned: ex_jump_addr=0x8000_0102.
  - Expect misalign_exc at T+1 for one cycle and misalign_addr=0x8000_0102.
  - Expect no redir_valid and no flush.
- Reset mid-DRAIN with stale=2: assert rst asynchronously between edges.
  - Expect outputs 0 and state IDLE immediately.
  - After release, a response arriving gives discard_resp=0.
- Counter wrap: preload 0xFFFF_FFFF via 2^32−1 accepts in a forced-state bench. Next accept gives redir_cnt=0.
